// File: rtl/bsg_mem_1rw_sync_mask_write_rmw_pkg.sv
// Shared types and helpers for the bsg_mem family of RAM wrappers.
// The RMW state enum lives here so other RMW variants can reuse it.
package bsg_mem_1rw_sync_mask_write_rmw_pkg;

    typedef enum logic [0:0] {
        e_rmw_idle  = 1'b0,
        e_rmw_merge = 1'b1
    } rmw_state_e;

    // clog2 that never returns 0, so single-word arrays still get a 1-bit address.
    function automatic int unsigned safe_clog2(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_rmw_if.sv
// Request/response bundle for the masked-write RMW RAM.
// Field names are written from the RAM's point of view.
interface bsg_mem_1rw_sync_mask_write_rmw_if #(
    parameter int unsigned width_p      = 32,
    parameter int unsigned addr_width_p = 4,
    parameter int unsigned mask_width_p = 4
);
    logic                    v_i;
    logic                    ready_o;
    logic                    w_i;
    logic [addr_width_p-1:0] addr_i;
    logic [width_p-1:0]      data_i;
    logic [mask_width_p-1:0] w_mask_i;
    logic [width_p-1:0]      data_o;
    logic                    v_o;

    modport master (
        output v_i, w_i, addr_i, data_i, w_mask_i,
        input  ready_o, data_o, v_o
    );

    modport slave (
        input  v_i, w_i, addr_i, data_i, w_mask_i,
        output ready_o, data_o, v_o
    );
endinterface

// File: rtl/bsg_expand_bitmask.sv
// Replicates each input bit expand_p times to form a bit-level mask.
module bsg_expand_bitmask #(
    parameter int unsigned in_width_p = 4,
    parameter int unsigned expand_p   = 8
) (
    input  logic [in_width_p-1:0]          i,
    output logic [in_width_p*expand_p-1:0] o
);
    for (genvar k = 0; k < in_width_p; k++) begin : g_expand
        assign o[k*expand_p +: expand_p] = {expand_p{i[k]}};
    end
endmodule

// File: rtl/bsg_mem_1rw_sync.sv
// Single-port synchronous RAM without write mask; read data appears the cycle after a read.
// Read data holds until the next read.
module bsg_mem_1rw_sync
    import bsg_mem_1rw_sync_mask_write_rmw_pkg::*;
#(
    parameter int unsigned width_p       = 32,
    parameter int unsigned els_p         = 16,
    parameter int unsigned addr_width_lp = safe_clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     v_i,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    output logic [width_p-1:0]       data_o
);
    logic [width_p-1:0] mem_q [els_p];
    logic [width_p-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (v_i) begin
            if (w_i) begin
                mem_q[addr_i] <= data_i;
            end else begin
                data_q <= mem_q[addr_i];
            end
        end
    end

    assign data_o = data_q;
endmodule

// File: rtl/bsg_mem_1rw_sync_mask_write_rmw.sv
// Masked-write single-port RAM built on an unmasked macro. Partial-mask writes
// become a two-cycle read-modify-write; full and zero masks complete in one cycle.
module bsg_mem_1rw_sync_mask_write_rmw
    import bsg_mem_1rw_sync_mask_write_rmw_pkg::*;
#(
    parameter int unsigned width_p           = 32,
    parameter int unsigned els_p             = 16,
    parameter int unsigned mask_gran_p       = 8,
    parameter bit          latch_last_read_p = 1'b1,
    parameter int unsigned addr_width_lp     = safe_clog2(els_p),
    parameter int unsigned mask_width_lp     = width_p / mask_gran_p
) (
    input  logic clk_i,
    input  logic reset_i,
    bsg_mem_1rw_sync_mask_write_rmw_if.slave bus_io
);
    if ((width_p % mask_gran_p) != 0) begin : g_gran_check
        $error("width_p must be a multiple of mask_gran_p");
    end

    rmw_state_e state_q, state_d;

    logic                     accept;
    logic                     mask_full, mask_zero;
    logic                     rd_accept, wr_full, wr_partial, merge_commit;
    logic                     ram_v, ram_w;
    logic [addr_width_lp-1:0] ram_addr;
    logic [width_p-1:0]       ram_wdata, ram_q, merged;
    logic [width_p-1:0]       mask_x;
    logic [addr_width_lp-1:0] addr_q;
    logic [width_p-1:0]       data_q, mask_x_q;
    logic                     v_o_q;

    assign bus_io.ready_o = (state_q == e_rmw_idle) & ~reset_i;
    assign accept         = bus_io.v_i & bus_io.ready_o;
    assign mask_full      = &bus_io.w_mask_i;
    assign mask_zero      = ~|bus_io.w_mask_i;

    assign rd_accept    = accept & ~bus_io.w_i;
    assign wr_full      = accept & bus_io.w_i & mask_full;
    assign wr_partial   = accept & bus_io.w_i & ~mask_full & ~mask_zero;
    // Reset in MERGE must not commit the half-finished write.
    assign merge_commit = (state_q == e_rmw_merge) & ~reset_i;

    bsg_expand_bitmask #(
        .in_width_p (mask_width_lp),
        .expand_p   (mask_gran_p)
    ) u_expand (
        .i (bus_io.w_mask_i),
        .o (mask_x)
    );

    assign merged = (ram_q & ~mask_x_q) | (data_q & mask_x_q);

    always_comb begin
        state_d   = state_q;
        ram_v     = rd_accept | wr_full | wr_partial | merge_commit;
        ram_w     = wr_full | merge_commit;
        ram_addr  = bus_io.addr_i;
        ram_wdata = bus_io.data_i;
        unique case (state_q)
            e_rmw_idle: begin
                if (wr_partial) state_d = e_rmw_merge;
            end
            e_rmw_merge: begin
                ram_addr  = addr_q;
                ram_wdata = merged;
                state_d   = e_rmw_idle;
            end
            default: state_d = e_rmw_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_rmw_idle;
            v_o_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            v_o_q   <= rd_accept;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_partial) begin
            addr_q   <= bus_io.addr_i;
            data_q   <= bus_io.data_i;
            mask_x_q <= mask_x;
        end
    end

    bsg_mem_1rw_sync #(
        .width_p (width_p),
        .els_p   (els_p)
    ) u_mem (
        .clk_i  (clk_i),
        .v_i    (ram_v),
        .w_i    (ram_w),
        .addr_i (ram_addr),
        .data_i (ram_wdata),
        .data_o (ram_q)
    );

    // A reset landing in the response cycle still squashes v_o.
    assign bus_io.v_o = v_o_q & ~reset_i;

    if (latch_last_read_p) begin : g_latch
        logic [width_p-1:0] last_q;

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                last_q <= '0;
            end else if (bus_io.v_o) begin
                last_q <= ram_q;
            end
        end

        assign bus_io.data_o = bus_io.v_o ? ram_q : last_q;
    end else begin : g_no_latch
        assign bus_io.data_o = ram_q;
    end

    localparam logic [addr_width_lp:0] els_lp = (addr_width_lp + 1)'(els_p);

    addr_in_range_a: assert property (@(posedge clk_i) disable iff (reset_i)
        accept |-> ({1'b0, bus_io.addr_i} < els_lp));
endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_rmw.sv
// Directed bench for the masked-write RMW RAM with a transaction-level memory model
// checked every cycle, plus literal expectations from hand-worked cases.
module tb_bsg_mem_1rw_sync_mask_write_rmw;
    localparam int unsigned W  = 32;
    localparam int unsigned N  = 16;
    localparam int unsigned G  = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned MW = 4;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    always #5 clk = ~clk;

    bsg_mem_1rw_sync_mask_write_rmw_if #(
        .width_p      (W),
        .addr_width_p (AW),
        .mask_width_p (MW)
    ) bus ();

    bsg_mem_1rw_sync_mask_write_rmw #(
        .width_p           (W),
        .els_p             (N),
        .mask_gran_p       (G),
        .latch_last_read_p (1'b1)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus_io  (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: memory contents, pending partial write, and the read result owed next cycle.
    logic [31:0] m_mem [N];
    bit          busy = 1'b0;
    logic [3:0]  p_addr;
    logic [31:0] p_data;
    logic [3:0]  p_mask;
    bit          exp_v = 1'b0;
    logic [31:0] exp_rd = '0;
    logic [31:0] last = '0;
    bit          started = 1'b0;

    function automatic logic [31:0] apply_mask(input logic [31:0] old, input logic [31:0] nw,
                                               input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset_i) begin
            busy    <= 1'b0;
            exp_v   <= 1'b0;
            last    <= '0;
            started <= 1'b1;
        end else begin
            if (exp_v) last <= exp_rd;
            exp_v <= 1'b0;
            if (busy) begin
                m_mem[p_addr] <= apply_mask(m_mem[p_addr], p_data, p_mask);
                busy <= 1'b0;
            end else if (bus.v_i) begin
                if (!bus.w_i) begin
                    exp_v  <= 1'b1;
                    exp_rd <= m_mem[bus.addr_i];
                end else if (bus.w_mask_i == 4'hF) begin
                    m_mem[bus.addr_i] <= bus.data_i;
                end else if (bus.w_mask_i != 4'h0) begin
                    busy   <= 1'b1;
                    p_addr <= bus.addr_i;
                    p_data <= bus.data_i;
                    p_mask <= bus.w_mask_i;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            bit ev;
            ev = exp_v && !reset_i;
            check("ready_o", 32'(bus.ready_o), 32'(!busy && !reset_i));
            check("v_o", 32'(bus.v_o), 32'(ev));
            check("data_o", bus.data_o, ev ? exp_rd : last);
        end
    end

    // Presents a request, holds it until accepted (bounded), returns just after the next negedge.
    task automatic req(input bit w, input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
        int n;
        bus.v_i = 1'b1;
        bus.w_i = w;
        bus.addr_i = a;
        bus.data_i = d;
        bus.w_mask_i = m;
        n = 0;
        while (!bus.ready_o && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("accept_timeout", 32'(n < 8), 32'd1);
        if (n < 8) @(posedge clk);
        @(negedge clk);
        #1;
        bus.v_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        bus.v_i = 1'b0;
        bus.w_i = 1'b0;
        bus.addr_i = '0;
        bus.data_i = '0;
        bus.w_mask_i = '0;
        for (int i = 0; i < N; i++) m_mem[i] = '0;
        idle(2);
        reset_i = 1'b0;

        for (int i = 0; i < N; i++) req(1'b1, 4'(i), 32'h1000_0000 + 32'(i) * 32'h0101_0101, 4'hF);

        // Full write then read.
        req(1'b1, 4'd3, 32'hDEAD_BEEF, 4'hF);
        check("lit_full_ready", 32'(bus.ready_o), 32'd1);
        req(1'b0, 4'd3, '0, 4'h0);
        check("lit_full_v", 32'(bus.v_o), 32'd1);
        check("lit_full_data", bus.data_o, 32'hDEAD_BEEF);

        // Partial write: one MERGE cycle with ready low.
        req(1'b1, 4'd3, 32'h1122_3344, 4'b0101);
        check("lit_merge_ready", 32'(bus.ready_o), 32'd0);
        req(1'b0, 4'd3, '0, 4'h0);
        check("lit_partial_data", bus.data_o, 32'hDE22_BE44);

        // Zero-mask write is a no-op at full throughput.
        req(1'b1, 4'd3, 32'h0, 4'h0);
        check("lit_zero_ready", 32'(bus.ready_o), 32'd1);
        req(1'b0, 4'd3, '0, 4'h0);
        check("lit_zero_data", bus.data_o, 32'hDE22_BE44);

        // Reset during MERGE drops the pending write.
        req(1'b1, 4'd5, 32'h0, 4'hF);
        req(1'b1, 4'd5, 32'hFFFF_FFFF, 4'b0011);
        reset_i = 1'b1;
        #1;
        check("lit_rst_ready", 32'(bus.ready_o), 32'd0);
        idle(1);
        check("lit_rst_v", 32'(bus.v_o), 32'd0);
        reset_i = 1'b0;
        req(1'b0, 4'd5, '0, 4'h0);
        check("lit_rst_merge_data", bus.data_o, 32'h0000_0000);

        // Read held across MERGE returns the merged word.
        req(1'b1, 4'd7, 32'hAABB_CCDD, 4'hF);
        req(1'b1, 4'd7, 32'h0102_0304, 4'b1000);
        req(1'b0, 4'd7, '0, 4'h0);
        check("lit_held_v", 32'(bus.v_o), 32'd1);
        check("lit_held_data", bus.data_o, 32'h01BB_CCDD);

        // Assorted partial masks, each followed by a read.
        req(1'b1, 4'd9, 32'hCAFE_F00D, 4'b0110);
        req(1'b0, 4'd9, '0, 4'h0);
        req(1'b1, 4'd10, 32'h5555_AAAA, 4'b1110);
        req(1'b0, 4'd10, '0, 4'h0);
        req(1'b1, 4'd15, 32'h0000_0077, 4'b0001);
        req(1'b1, 4'd0, 32'h8800_0000, 4'b1000);
        req(1'b0, 4'd15, '0, 4'h0);
        req(1'b0, 4'd0, '0, 4'h0);

        // Reset in the response cycle squashes v_o.
        req(1'b0, 4'd7, '0, 4'h0);
        reset_i = 1'b1;
        #1;
        check("lit_rst_resp_v", 32'(bus.v_o), 32'd0);
        idle(1);
        reset_i = 1'b0;

        // Latched read data holds across idle cycles and clears on reset.
        req(1'b0, 4'd3, '0, 4'h0);
        idle(5);
        check("lit_latch_data", bus.data_o, 32'hDE22_BE44);
        check("lit_latch_v", 32'(bus.v_o), 32'd0);
        reset_i = 1'b1;
        idle(1);
        check("lit_latch_rst", bus.data_o, 32'h0);
        reset_i = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
